// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for the NTT input staging path.
//   W       - default coefficient width in bits
//   N       - default coefficients per frame (power of 2)
//   LOG2N   - index width for a frame slot
//   coeff_t - one coefficient
//   bank_state_e - occupancy state of one frame bank
//   bitrev  - bit-reversal of a LOG2N-bit slot index
package ntt_pkg;

  localparam int unsigned W     = 8;
  localparam int unsigned N     = 8;
  localparam int unsigned LOG2N = $clog2(N);

  typedef logic [W-1:0] coeff_t;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Mirror the index bits: bit k moves to bit LOG2N-1-k.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] rev;
    rev = '0;
    for (int k = 0; k < int'(LOG2N); k++) begin
      rev[k] = idx[int'(LOG2N) - 1 - k];
    end
    return rev;
  endfunction

endpackage

// File: rtl/ntt_frame_bank.sv
// ntt_frame_bank: one frame bank of the ping-pong stager.
// Holds N coefficients of W bits and tracks EMPTY / FILLING / FULL.
//   clk, rst_n     - clock, synchronous active-low reset
//   wr_en_i        - write wr_data_i into slot wr_slot_i this cycle
//   wr_slot_i      - destination slot (already bit-reversed)
//   wr_data_i      - coefficient to store
//   wr_last_i      - this write completes the frame (bank goes FULL)
//   abort_i        - discard the partial frame (bank goes EMPTY)
//   release_i      - frame consumed downstream (FULL goes EMPTY)
//   state_nxt_c_o  - state the bank takes at the next edge (combinational)
//   data_o         - stored frame, slot order
module ntt_frame_bank #(
  parameter int unsigned W    = ntt_pkg::W,
  parameter int unsigned N    = ntt_pkg::N,
  parameter int unsigned IDXW = ntt_pkg::LOG2N
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_i,
  input  logic [IDXW-1:0]           wr_slot_i,
  input  logic [W-1:0]              wr_data_i,
  input  logic                      wr_last_i,
  input  logic                      abort_i,
  input  logic                      release_i,
  output ntt_pkg::bank_state_e      state_nxt_c_o,
  output logic [N-1:0][W-1:0]       data_o
);
  import ntt_pkg::*;

  bank_state_e         state_q, state_d;
  logic [N-1:0][W-1:0] data_q;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BANK_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BANK_EMPTY: begin
        if (!abort_i && wr_en_i) begin
          state_d = wr_last_i ? BANK_FULL : BANK_FILLING;
        end
      end
      BANK_FILLING: begin
        if (abort_i) begin
          state_d = BANK_EMPTY;
        end else if (wr_en_i && wr_last_i) begin
          state_d = BANK_FULL;
        end
      end
      BANK_FULL: begin
        if (release_i) begin
          state_d = BANK_EMPTY;
        end
      end
      default: state_d = BANK_EMPTY;
    endcase
  end

  // Coefficient storage; a FULL bank is frozen until released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (wr_en_i && (state_q != BANK_FULL)) begin
      data_q[wr_slot_i] <= wr_data_i;
    end
  end

  assign state_nxt_c_o = state_d;
  assign data_o        = data_q;

endmodule

// File: rtl/ntt8_input_stager.sv
// ntt8_input_stager: collects natural-order coefficients into bit-reversed
// frames using two ping-pong banks and presents whole frames downstream.
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - coefficient handshake
//   in_data, in_last     - coefficient (natural order), end-of-frame marker
//   mod                  - modulus q, static while busy
//   out_valid/out_ready  - frame handshake
//   out_data             - frame; element i = coefficient at index bitrev(i)
//   err                  - one-cycle pulse on framing or range fault
module ntt8_input_stager #(
  parameter int unsigned W = ntt_pkg::W,
  parameter int unsigned N = ntt_pkg::N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  input  logic                in_last,
  input  logic [W-1:0]        mod,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0][W-1:0] out_data,
  output logic                err
);
  import ntt_pkg::*;

  localparam int unsigned IDXW  = LOG2N;
  localparam int unsigned NBANK = 2;

  logic [IDXW-1:0]     wr_idx_q, wr_idx_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;
  logic [N-1:0][W-1:0] out_data_q, out_data_d;

  logic                accept_c;
  logic                handshake_c;
  logic                at_last_slot_c;
  logic                frame_abort_c;
  logic                frame_done_c;
  logic                range_fault_c;
  logic [W-1:0]        mod_diff_c;
  logic [W-1:0]        store_val_c;
  logic [IDXW-1:0]     wr_slot_c;
  logic [N-1:0][W-1:0] rd_image_c;

  logic                bank_wr_en    [NBANK];
  logic                bank_abort    [NBANK];
  logic                bank_release  [NBANK];
  bank_state_e         bank_state_nxt[NBANK];
  logic [N-1:0][W-1:0] bank_data     [NBANK];

  assign accept_c       = in_valid && in_ready_q;
  assign handshake_c    = out_valid_q && out_ready;
  assign at_last_slot_c = (wr_idx_q == IDXW'(N - 1));
  assign frame_abort_c  = accept_c && in_last && !at_last_slot_c;
  assign frame_done_c   = accept_c && at_last_slot_c;
  assign range_fault_c  = accept_c && (in_data >= mod);
  assign wr_slot_c      = bitrev(wr_idx_q);

  // Single-subtraction range fold; anything still out of range becomes 0.
  always_comb begin
    mod_diff_c  = in_data - mod;
    store_val_c = in_data;
    if (in_data >= mod) begin
      store_val_c = (mod_diff_c < mod) ? mod_diff_c : '0;
    end
  end

  // Steer write/abort to the write bank and release to the read bank.
  always_comb begin
    for (int b = 0; b < int'(NBANK); b++) begin
      bank_wr_en[b]   = 1'b0;
      bank_abort[b]   = 1'b0;
      bank_release[b] = 1'b0;
    end
    bank_wr_en[wr_ptr_q]   = accept_c && !frame_abort_c;
    bank_abort[wr_ptr_q]   = frame_abort_c;
    bank_release[rd_ptr_q] = handshake_c;
  end

  for (genvar b = 0; b < int'(NBANK); b++) begin : g_bank
    ntt_frame_bank #(
      .W    (W),
      .N    (N),
      .IDXW (IDXW)
    ) u_bank (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en_i       (bank_wr_en[b]),
      .wr_slot_i     (wr_slot_c),
      .wr_data_i     (store_val_c),
      .wr_last_i     (frame_done_c),
      .abort_i       (bank_abort[b]),
      .release_i     (bank_release[b]),
      .state_nxt_c_o (bank_state_nxt[b]),
      .data_o        (bank_data[b])
    );
  end

  // Pointer, handshake and output next-state logic.
  always_comb begin
    wr_idx_d   = wr_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_data_d = out_data_q;

    if (accept_c) begin
      if (frame_abort_c || frame_done_c) begin
        wr_idx_d = '0;
      end else begin
        wr_idx_d = wr_idx_q + IDXW'(1);
      end
    end
    if (frame_done_c) begin
      wr_ptr_d = !wr_ptr_q;
    end
    if (handshake_c) begin
      rd_ptr_d = !rd_ptr_q;
    end

    in_ready_d  = (bank_state_nxt[wr_ptr_d] != BANK_FULL);
    out_valid_d = (bank_state_nxt[rd_ptr_d] == BANK_FULL);
    err_d       = frame_abort_c || (frame_done_c && !in_last) || range_fault_c;

    // Frame as it will stand after this edge, including a same-cycle final write.
    rd_image_c = bank_data[rd_ptr_d];
    if (bank_wr_en[rd_ptr_d]) begin
      rd_image_c[wr_slot_c] = store_val_c;
    end
    // Load only when a new frame is presented; hold while stalled.
    if (out_valid_d && (!out_valid_q || handshake_c)) begin
      out_data_d = rd_image_c;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx_q    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_ntt8_input_stager.sv
// tb_ntt8_input_stager: directed and randomized stimulus for the stager,
// checked against a frame-queue reference model.
module tb_ntt8_input_stager;
  import ntt_pkg::*;

  localparam int unsigned DW   = N * W;
  localparam int          LAST = int'(N) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  coeff_t              in_data;
  logic                in_last;
  coeff_t              mod;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0][W-1:0] out_data;
  logic                err;

  always #5 clk = ~clk;

  ntt8_input_stager #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mod       (mod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err)
  );

  int n_checks;
  int n_errors;

  // Reference model: completed frames queued in arrival order.
  logic [DW-1:0] pend_q[$];
  int            part[N];
  int            part_cnt;
  bit            m_ready, m_valid, m_err, m_dchk;
  logic [DW-1:0] m_data;
  bit            last_acc;
  int            acc_cnt;

  logic [W:0]    stim_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int rev_idx(input int i);
    int r, x;
    r = 0;
    x = i;
    for (int k = 0; k < int'(LOG2N); k++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pack_frame();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(N); i++) begin
      v[i*W +: W] = W'(part[rev_idx(i)]);
    end
    return v;
  endfunction

  // Advance the model over one clock edge, then compare after the edge.
  task automatic tick();
    int d, q, v;
    last_acc = 1'b0;
    if (!rst_n) begin
      pend_q.delete();
      part_cnt = 0;
      m_ready  = 1'b0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      m_data   = '0;
      m_dchk   = 1'b1;
    end else begin
      last_acc = in_valid && m_ready;
      m_err    = 1'b0;
      if (m_valid && out_ready) begin
        void'(pend_q.pop_front());
        m_dchk = 1'b0;
      end
      if (last_acc) begin
        acc_cnt++;
        d = int'(in_data);
        q = int'(mod);
        v = d;
        if (d >= q) begin
          m_err = 1'b1;
          v = (d - q < q) ? d - q : 0;
        end
        if (in_last && part_cnt != LAST) begin
          part_cnt = 0;
          m_err    = 1'b1;
        end else begin
          part[part_cnt] = v;
          if (part_cnt == LAST) begin
            if (!in_last) m_err = 1'b1;
            pend_q.push_back(pack_frame());
            part_cnt = 0;
          end else begin
            part_cnt++;
          end
        end
      end
      m_ready = pend_q.size() < 2;
      m_valid = pend_q.size() > 0;
      if (m_valid) begin
        m_data = pend_q[0];
        m_dchk = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("in_ready", DW'(in_ready), DW'(m_ready));
    chk("out_valid", DW'(out_valid), DW'(m_valid));
    chk("err", DW'(err), DW'(m_err));
    if (m_dchk) chk("out_data", out_data, m_data);
  endtask

  task automatic push_item(input int d, input bit last);
    stim_q.push_back({last, W'(d)});
  endtask

  task automatic push_frame(input int len, input int last_at, input bit rnd, input int base);
    for (int i = 0; i < len; i++) begin
      push_item(rnd ? int'($urandom_range(255)) : base + i, i == last_at);
    end
  endtask

  // Offer queued coefficients; vpct/rpct are valid/ready probabilities in percent.
  task automatic run(input int cycles, input int vpct, input int rpct);
    for (int c = 0; c < cycles; c++) begin
      in_valid = (stim_q.size() > 0) && (int'($urandom_range(99)) < vpct);
      if (stim_q.size() > 0) {in_last, in_data} = stim_q[0];
      else {in_last, in_data} = '0;
      out_ready = int'($urandom_range(99)) < rpct;
      tick();
      if (last_acc) void'(stim_q.pop_front());
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_frame;
    int            k, len;
    n_checks  = 0;
    n_errors  = 0;
    acc_cnt   = 0;
    part_cnt  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    mod       = W'(17);
    out_ready = 1'b0;

    // Reset state, then in_ready on the first cycle out of reset.
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", DW'(in_ready), DW'(1'b1));

    // Frame 0..7 lands in bit-reversed order.
    push_frame(8, 7, 1'b0, 0);
    run(9, 100, 0);
    exp_frame = {8'd7, 8'd3, 8'd5, 8'd1, 8'd6, 8'd2, 8'd4, 8'd0};
    chk("bitrev_frame", out_data, exp_frame);
    chk("bitrev_valid", DW'(out_valid), DW'(1'b1));
    run(2, 0, 100);

    // Back-pressure: three frames offered, only two banks to hold them.
    acc_cnt = 0;
    for (int f = 0; f < 3; f++) push_frame(8, 7, 1'b0, 1 + f);
    run(30, 100, 0);
    chk("stall_accepts", DW'(acc_cnt), DW'(16));
    chk("stall_in_ready", DW'(in_ready), DW'(1'b0));
    run(24, 100, 100);

    // Sustained one-per-cycle throughput.
    acc_cnt = 0;
    for (int f = 0; f < 4; f++) push_frame(8, 7, 1'b1, 0);
    run(32, 100, 100);
    chk("stream_accepts", DW'(acc_cnt), DW'(32));
    run(4, 0, 100);

    // Early in_last discards the partial frame; the next one is intact.
    push_frame(3, 2, 1'b0, 9);
    push_frame(8, 7, 1'b0, 2);
    run(16, 100, 100);

    // Range fold: 20 mod 17 -> 3 at slot 4, 40 -> 0 at slot 2.
    mod = W'(17);
    push_item(5, 1'b0);
    push_item(20, 1'b0);
    push_item(40, 1'b0);
    for (int i = 3; i < 8; i++) push_item(i, i == 7);
    run(8, 100, 0);
    chk("range_fold", DW'(out_data[4]), DW'(3));
    chk("range_zero", DW'(out_data[2]), DW'(0));
    run(2, 0, 100);

    // Reset with one frame FULL and a partial frame in flight.
    push_frame(8, 7, 1'b0, 0);
    push_frame(8, 7, 1'b0, 8);
    run(13, 100, 0);
    rst_n = 1'b0;
    stim_q.delete();
    tick();
    chk("midrst_valid", DW'(out_valid), DW'(1'b0));
    chk("midrst_ready", DW'(in_ready), DW'(1'b0));
    rst_n = 1'b1;
    tick();
    push_frame(8, 7, 1'b1, 0);
    push_frame(8, 7, 1'b1, 0);
    run(24, 100, 100);

    // Randomized traffic with occasional framing and range faults.
    for (int r = 0; r < 3; r++) begin
      rst_n = 1'b0;
      stim_q.delete();
      tick();
      rst_n = 1'b1;
      mod = W'($urandom_range(255, 1));
      tick();
      for (int f = 0; f < 15; f++) begin
        k = int'($urandom_range(9));
        if (k == 0) begin
          len = int'($urandom_range(LAST, 1));
          push_frame(len, len - 1, 1'b1, 0);
        end else if (k == 1) begin
          push_frame(8, -1, 1'b1, 0);
        end else begin
          push_frame(8, 7, 1'b1, 0);
        end
      end
      run(300, 70, 60);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ntt8_input_stager.md
NTT8_INPUT_STAGER -- requirements
Module: ntt8_input_stager

Interface
REQ-001 SHALL have parameter W, default 8, coefficient width in bits.
REQ-002 SHALL have parameter N, default 8, coefficients per frame (power of 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream coefficient valid.
REQ-006 SHALL have port in_ready  output  1  stager can accept a coefficient.
REQ-007 SHALL have port in_data  input  W  coefficient, natural order.
REQ-008 SHALL have port in_last  input  1  marks the final coefficient of a frame.
REQ-009 SHALL have port mod  input  W  modulus q; held static while not idle.
REQ-010 SHALL have port out_valid  output  1  complete bit-reversed frame available.
REQ-011 SHALL have port out_ready  input  1  downstream butterfly network consumes frame.
REQ-012 SHALL have port out_data  output  N x W  frame; element i = coefficient at natural index bitrev(i).
REQ-013 SHALL have port err  output  1  one-cycle pulse on a framing or range fault.

Function
REQ-014 SHALL hold two frame banks (ping-pong), each with state EMPTY, FILLING or FULL.
REQ-015 SHALL accept a coefficient only when in_valid && in_ready, writing it to slot bitrev(wr_idx) of the write bank.
REQ-016 SHALL drive in_ready high iff the write bank is EMPTY or FILLING.
REQ-017 SHALL keep a log2(N)-bit wr_idx counter, incremented per accept and wrapped to 0 after N-1.
REQ-018 SHALL mark the write bank FULL when the accept at wr_idx=N-1 occurs, then switch the write pointer to the other bank.
REQ-019 SHALL assert out_valid on the cycle after the FULL transition when the read bank is that bank; frames are delivered in arrival order.
REQ-020 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL on out_valid && out_ready set the read bank EMPTY and advance the read pointer the next cycle.
REQ-022 SHALL, when a frame completes and the other bank is consumed in the same cycle, perform both transitions with no lost cycle; sustained throughput is one coefficient per cycle.
REQ-023 SHALL, when in_last arrives at wr_idx != N-1, discard the partial frame (bank to EMPTY, wr_idx to 0) and pulse err.
REQ-024 SHALL, when wr_idx = N-1 is accepted without in_last, complete the frame normally and pulse err.
REQ-025 SHALL, when an accepted in_data >= mod, store in_data - mod if that difference is < mod, else store 0, and pulse err.
REQ-026 SHALL keep err low in all other cycles; multiple faults in one cycle give a single pulse.

Reset
REQ-027 SHALL on rst_n low at a clock edge set both banks EMPTY, wr_idx 0, both pointers to bank 0, in_ready 0, out_valid 0, err 0, out_data all zero.
REQ-028 SHALL drive in_ready 1 the first cycle after rst_n returns high.
REQ-029 SHALL discard any partial or undelivered frame on reset mid-operation; no stale data shall appear after reset.

Structure
REQ-030 SHALL take W, N, LOG2N, a coeff_t typedef and a bitrev(idx) function from the shared package ntt_pkg.
REQ-031 SHALL contain one sub-module, ntt_frame_bank (one bank: N x W storage, state, write port); the stager instantiates two.

Verification
REQ-032 SHALL cover: mod=17, frame 0..7 with in_last on the 8th -> out_data = {0,4,2,6,1,5,3,7}, out_valid 1 cycle after the last accept, err 0.
REQ-033 SHALL cover: out_ready held 0, three frames offered -> two accepted, in_ready 0 from the 16th accept, out_data stable; out_ready 1 -> frames 1 then 2 delivered in order.
REQ-034 SHALL cover: continuous in_valid and out_ready, 4 frames -> 32 accepts in 32 cycles, no in_ready bubble.
REQ-035 SHALL cover: in_last at the 3rd coefficient -> err pulse, no out_valid; the next 8-coefficient frame is delivered intact.
REQ-036 SHALL cover: mod=17, in_data=20 at index 1 -> slot bitrev(1)=4 holds 3, err pulse; in_data=40 -> slot holds 0, err pulse.
REQ-037 SHALL cover: rst_n low after the 5th coefficient and with one frame FULL -> next cycle out_valid 0, in_ready 0; then in_ready 1 and clean frames are delivered.
